// File: rtl/pooling_window_buffer_pkg.sv
// Shared definitions for the pooling window path: default window edge,
// element-index helper shared with max_pooling_unit, and counter sizing.
package pooling_window_buffer_pkg;

  localparam int POOL_DIM_DEFAULT = 2;

  // Element index of (row r, column c) inside a dim x dim window.
  function automatic int pool_idx(input int r, input int c, input int dim);
    return r * dim + c;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pooling_window_buffer_line_buffer.sv
// Holds the first POOL_DIM-1 rows of the current window band and presents
// the POOL_DIM columns ending at rd_col for every stored row.
module pool_line_buffer
  import pooling_window_buffer_pkg::*;
#(
  parameter int POOL_DIM  = POOL_DIM_DEFAULT,
  parameter int I_WIDTH   = 8,
  parameter int IMG_WIDTH = 8,
  localparam int CW       = cnt_width(IMG_WIDTH),
  localparam int PW       = cnt_width(POOL_DIM),
  localparam int LB_W     = (POOL_DIM - 1) * POOL_DIM * I_WIDTH
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PW-1:0]      row_sel,
  input  logic [CW-1:0]      wr_col,
  input  logic [I_WIDTH-1:0] wr_data,
  input  logic [CW-1:0]      rd_col,
  output logic [LB_W-1:0]    rd_data
);

  logic [I_WIDTH-1:0] mem [POOL_DIM-1][IMG_WIDTH];

  // NOTE: storage has no reset; every location is written before it is read
  // in each band, so resetting it would only cost a large reset fan-out.
  always_ff @(posedge clk) begin
    if (we) mem[row_sel][wr_col] <= wr_data;
  end

  // rd_col is the last column of the window, so the band starts POOL_DIM-1 back.
  always_comb begin
    rd_data = '0;
    for (int r = 0; r < POOL_DIM - 1; r++) begin
      for (int c = 0; c < POOL_DIM; c++) begin
        rd_data[I_WIDTH*pool_idx(r, c, POOL_DIM) +: I_WIDTH] =
          mem[r][rd_col - CW'(POOL_DIM - 1 - c)];
      end
    end
  end

endmodule

// File: rtl/pooling_window_buffer.sv
// Streaming raster-to-window converter: builds non-overlapping POOL_DIM x POOL_DIM
// windows from a one-element-per-beat feature map, feeding max_pooling_unit.
module pooling_window_buffer
  import pooling_window_buffer_pkg::*;
#(
  parameter int POOL_DIM   = POOL_DIM_DEFAULT,
  parameter int I_WIDTH    = 8,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  localparam int SIZE      = POOL_DIM * POOL_DIM
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [I_WIDTH-1:0]      in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [I_WIDTH*SIZE-1:0] window_data,
  output logic                    window_valid,
  input  logic                    window_ready,
  output logic                    frame_done
);

  localparam int CW   = cnt_width(IMG_WIDTH);
  localparam int RW   = cnt_width(IMG_HEIGHT);
  localparam int PW   = cnt_width(POOL_DIM);
  localparam int LB_W = (POOL_DIM - 1) * POOL_DIM * I_WIDTH;

  if ((IMG_WIDTH % POOL_DIM) != 0 || (IMG_HEIGHT % POOL_DIM) != 0 || POOL_DIM < 2)
  begin : g_bad_dims
    $error("pooling_window_buffer: image dimensions must be multiples of POOL_DIM >= 2");
  end

  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic [PW-1:0]           rphase, cphase;
  logic [I_WIDTH-1:0]      sr [POOL_DIM-1];
  logic [LB_W-1:0]         lb_rd;
  logic [I_WIDTH*SIZE-1:0] win_next;
  logic                    window_last;
  logic                    in_fire, out_fire, last_row, complete;

  assign in_ready = !window_valid || window_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = window_valid && window_ready;
  assign last_row = (rphase == PW'(POOL_DIM - 1));
  assign complete = in_fire && last_row && (cphase == PW'(POOL_DIM - 1));

  pool_line_buffer #(
    .POOL_DIM  (POOL_DIM),
    .I_WIDTH   (I_WIDTH),
    .IMG_WIDTH (IMG_WIDTH)
  ) u_line_buffer (
    .clk     (clk),
    .we      (in_fire && !last_row),
    .row_sel (rphase),
    .wr_col  (col),
    .wr_data (in_data),
    .rd_col  (col),
    .rd_data (lb_rd)
  );

  always_ff @(posedge clk) begin
    if (in_fire && last_row) begin
      for (int i = 0; i < POOL_DIM - 2; i++) sr[i] <= sr[i+1];
      sr[POOL_DIM-2] <= in_data;
    end
  end

  // NOTE: every output is given a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    win_next = '0;
    win_next[0 +: LB_W] = lb_rd;
    for (int c = 0; c < POOL_DIM - 1; c++) begin
      win_next[I_WIDTH*pool_idx(POOL_DIM - 1, c, POOL_DIM) +: I_WIDTH] = sr[c];
    end
    win_next[I_WIDTH*(SIZE-1) +: I_WIDTH] = in_data;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col          <= '0;
      row          <= '0;
      rphase       <= '0;
      cphase       <= '0;
      window_data  <= '0;
      window_valid <= 1'b0;
      window_last  <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= out_fire && window_last;
      if (in_fire) begin
        if (col == CW'(IMG_WIDTH - 1)) begin
          col    <= '0;
          cphase <= '0;
          rphase <= last_row ? '0 : rphase + PW'(1);
          row    <= (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + RW'(1);
        end else begin
          col    <= col + CW'(1);
          cphase <= (cphase == PW'(POOL_DIM - 1)) ? '0 : cphase + PW'(1);
        end
      end
      // A completing beat wins over a handshake so back-to-back windows have no bubble.
      if (complete) begin
        window_data  <= win_next;
        window_valid <= 1'b1;
        window_last  <= (row == RW'(IMG_HEIGHT - 1)) && (col == CW'(IMG_WIDTH - 1));
      end else if (out_fire) begin
        window_valid <= 1'b0;
      end
    end
  end

endmodule
